// File: rtl/battlefront_calc_pkg.sv
// Shared constants, state encoding and empty-front defaults for the battlefront calculator.
package battlefront_calc_pkg;

  localparam int NUM_SLOTS   = 4;
  localparam int POS_W       = 9;
  localparam int DMG_W       = 8;
  localparam int TICK_CYCLES = 16;

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [POS_W-1:0] POS_MAX = '1;
  localparam logic [DMG_W-1:0] DMG_MAX = '1;

  // A front with nobody alive: enemies sit at the origin, units at the far edge.
  localparam logic [POS_W-1:0] ENEMY_FRONT_EMPTY = '0;
  localparam logic [POS_W-1:0] UNIT_FRONT_EMPTY  = POS_MAX;

  typedef enum logic [3:0] {
    S_WAIT   = 4'b0001,
    S_SCAN   = 4'b0010,
    S_DAMAGE = 4'b0100,
    S_MOVE   = 4'b1000
  } state_t;

endpackage

// File: rtl/battlefront_calc_if.sv
// Slot inputs, published results and strobes of the battlefront calculator.
interface battlefront_calc_if;
  import battlefront_calc_pkg::*;

  logic                       enable;
  logic [NUM_SLOTS*POS_W-1:0] unitPos;
  logic [NUM_SLOTS-1:0]       unitDead;
  logic [NUM_SLOTS*DMG_W-1:0] unitDmg;
  logic [NUM_SLOTS*POS_W-1:0] enemyPos;
  logic [NUM_SLOTS-1:0]       enemyDead;
  logic [NUM_SLOTS*DMG_W-1:0] enemyDmg;
  logic [POS_W-1:0]           enemyFront;
  logic [POS_W-1:0]           unitFront;
  logic [DMG_W-1:0]           damageToUnits;
  logic [DMG_W-1:0]           damageToEnemies;
  logic                       damageSCEN;
  logic                       moveSCEN;
  state_t                     state_dbg;

  // No ready path: damageSCEN and moveSCEN are one-cycle fire-and-forget strobes,
  // and the front/damage outputs are already stable when damageSCEN is high.
  modport master (
    output enable, unitPos, unitDead, unitDmg, enemyPos, enemyDead, enemyDmg,
    input  enemyFront, unitFront, damageToUnits, damageToEnemies,
           damageSCEN, moveSCEN, state_dbg
  );

  modport slave (
    input  enable, unitPos, unitDead, unitDmg, enemyPos, enemyDead, enemyDmg,
    output enemyFront, unitFront, damageToUnits, damageToEnemies,
           damageSCEN, moveSCEN, state_dbg
  );

endinterface

// File: rtl/battlefront_calc_sat_add.sv
// Unsigned adder that clamps to all ones instead of wrapping.
module sat_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    y    = full[W] ? {W{1'b1}} : full[W-1:0];
  end

endmodule

// File: rtl/battlefront_calc.sv
// Per-tick scan of all unit/enemy slots, publishing fronts and saturated damage totals.
module battlefront_calc
  import battlefront_calc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  battlefront_calc_if.slave  bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tick_cnt;
  logic [IDX_W-1:0] idx;

  logic [POS_W-1:0] enc_max, unit_min, enc_max_nxt, unit_min_nxt;
  logic [DMG_W-1:0] sum_e, sum_u, sum_e_nxt, sum_u_nxt;

  logic [POS_W-1:0] e_pos, u_pos;
  logic [DMG_W-1:0] e_dmg, u_dmg, e_addend, u_addend;
  logic             e_live, u_live, tick_last, scan_last;

  assign tick_last = (tick_cnt == CNT_W'(TICK_CYCLES - 1));
  assign scan_last = (idx == IDX_W'(NUM_SLOTS - 1));

  assign e_pos  = bus.enemyPos[idx*POS_W +: POS_W];
  assign u_pos  = bus.unitPos[idx*POS_W +: POS_W];
  assign e_dmg  = bus.enemyDmg[idx*DMG_W +: DMG_W];
  assign u_dmg  = bus.unitDmg[idx*DMG_W +: DMG_W];
  assign e_live = !bus.enemyDead[idx];
  assign u_live = !bus.unitDead[idx];

  // Dead slots feed a zero addend so the adders stay free-running.
  assign e_addend = e_live ? e_dmg : '0;
  assign u_addend = u_live ? u_dmg : '0;

  assign enc_max_nxt  = (e_live && (e_pos > enc_max))  ? e_pos : enc_max;
  assign unit_min_nxt = (u_live && (u_pos < unit_min)) ? u_pos : unit_min;

  sat_add #(.W(DMG_W)) u_sat_e (.a(sum_e), .b(e_addend), .y(sum_e_nxt));
  sat_add #(.W(DMG_W)) u_sat_u (.a(sum_u), .b(u_addend), .y(sum_u_nxt));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_WAIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.damageSCEN = 1'b0;
    bus.moveSCEN   = 1'b0;
    case (state)
      S_WAIT:   if (bus.enable && tick_last) state_nxt = S_SCAN;
      S_SCAN:   if (scan_last) state_nxt = S_DAMAGE;
      S_DAMAGE: begin
        bus.damageSCEN = 1'b1;
        state_nxt      = S_MOVE;
      end
      S_MOVE: begin
        bus.moveSCEN = 1'b1;
        state_nxt    = S_WAIT;
      end
      default:  state_nxt = S_WAIT;
    endcase
  end

  assign bus.state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt            <= '0;
      idx                 <= '0;
      enc_max             <= ENEMY_FRONT_EMPTY;
      unit_min            <= UNIT_FRONT_EMPTY;
      sum_e               <= '0;
      sum_u               <= '0;
      bus.enemyFront      <= ENEMY_FRONT_EMPTY;
      bus.unitFront       <= UNIT_FRONT_EMPTY;
      bus.damageToUnits   <= '0;
      bus.damageToEnemies <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (bus.enable) begin
            if (tick_last) begin
              tick_cnt <= '0;
              idx      <= '0;
              enc_max  <= ENEMY_FRONT_EMPTY;
              unit_min <= UNIT_FRONT_EMPTY;
              sum_e    <= '0;
              sum_u    <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_SCAN: begin
          enc_max  <= enc_max_nxt;
          unit_min <= unit_min_nxt;
          sum_e    <= sum_e_nxt;
          sum_u    <= sum_u_nxt;
          idx      <= scan_last ? '0 : idx + 1'b1;
          // Publish on the last slot so results are stable for the whole damage/move pair.
          if (scan_last) begin
            bus.enemyFront      <= enc_max_nxt;
            bus.unitFront       <= unit_min_nxt;
            bus.damageToUnits   <= sum_e_nxt;
            bus.damageToEnemies <= sum_u_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/battlefront_calc.md
Name: battlefront_calc

Overview:
- Sits upstream of the per-slot Unit and Enemy instances and feeds them the front positions, damage totals and move/damage strobes.
- Once per game tick it scans all slots, one per cycle, then publishes the results:
  - frontmost live enemy position, to the units;
  - frontmost live unit position, to the enemies;
  - saturated total damage, in each direction.
- It then pulses damageSCEN followed by moveSCEN.

Parameters:
- NUM_SLOTS, 4, number of unit slots and number of enemy slots (equal).
- POS_W, 9, position width.
- DMG_W, 8, damage/power width.
- TICK_CYCLES, 16, clk cycles per game tick; must be >= NUM_SLOTS+3.

Ports:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- enable  in  1  tick counter advances only when 1 (pause)
- unitPos  in  NUM_SLOTS*POS_W  unit positions, slot i at [i*POS_W +: POS_W]
- unitDead  in  NUM_SLOTS  1 = unit slot empty/dead
- unitDmg  in  NUM_SLOTS*DMG_W  unit damageOut per slot
- enemyPos  in  NUM_SLOTS*POS_W  enemy positions
- enemyDead  in  NUM_SLOTS  1 = enemy slot empty/dead
- enemyDmg  in  NUM_SLOTS*DMG_W  enemy damageOut per slot
- enemyFront  out  POS_W  max position of live enemies, to units
- unitFront  out  POS_W  min position of live units, to enemies
- damageToUnits  out  DMG_W  saturated sum of live enemyDmg
- damageToEnemies  out  DMG_W  saturated sum of live unitDmg
- damageSCEN  out  1  one-cycle damage strobe
- moveSCEN  out  1  one-cycle move strobe

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- Reset values:
  - enemyFront = 0;
  - unitFront = all ones (511);
  - damageToUnits = damageToEnemies = 0;
  - damageSCEN = moveSCEN = 0;
  - tick counter = 0, scan index = 0, state = S_WAIT.
- States: S_WAIT, S_SCAN, S_DAMAGE, S_MOVE.
- S_WAIT:
  - If enable, the counter increments; it holds otherwise.
  - When the counter == TICK_CYCLES-1 and enable: counter <= 0, index <= 0, accumulators initialised (encMax=0, unitMin=all ones, sums=0), go to S_SCAN.
- S_SCAN, one slot per cycle at index i, sampling inputs that cycle:
  - If !enemyDead[i]: encMax = max(encMax, enemyPos[i]) and sumE += enemyDmg[i].
  - If !unitDead[i]: unitMin = min(unitMin, unitPos[i]) and sumU += unitDmg[i].
  - Sums saturate at 2^DMG_W-1: compute in DMG_W+1 bits, clamp.
  - At i == NUM_SLOTS-1, register enemyFront, unitFront, damageToUnits=sumE and damageToEnemies=sumU, then go to S_DAMAGE.
- S_DAMAGE: damageSCEN=1 for exactly this cycle; outputs already stable. Next state S_MOVE.
- S_MOVE: moveSCEN=1 for exactly this cycle. Next state S_WAIT.
- Latency: tick decision at cycle T → scan T+1..T+NUM_SLOTS → damageSCEN at T+NUM_SLOTS+1 → moveSCEN at T+NUM_SLOTS+2.
- The tick counter is frozen outside S_WAIT. Tick period = TICK_CYCLES + NUM_SLOTS + 2 cycles when enable is held.
- Outputs hold their last published values between ticks. They change only on the last scan cycle.
- Boundary conditions:
  - No live enemies → enemyFront = 0, damageToUnits = 0.
  - No live units → unitFront = all ones, damageToEnemies = 0.
  - Equal positions: any tie gives the same value.
  - Dead slots contribute nothing, even with nonzero Dmg/Pos.
- enable deasserted mid-scan has no effect; the scan, damage and move sequence completes.
- Reset mid-operation aborts immediately to reset values; no strobe is emitted.
- damageSCEN and moveSCEN are never high in the same cycle.

Decomposition:
- Shared package holds:
  - state encodings (one-hot, 4 bits);
  - POS_MAX (all ones) and DMG_MAX (saturation value);
  - the empty-front defaults.
- One sub-module: sat_add (DMG_W-wide saturating adder), instantiated twice.

Test Plan:
All scenarios use NUM_SLOTS=4, TICK_CYCLES=16.
- Reset then hold enable=1, all slots dead: after 16 cycles, 4 scan cycles → damageSCEN pulses at cycle 21 and moveSCEN at cycle 22. Result: enemyFront=0, unitFront=511, both damages 0. Next pulses come 22 cycles later.
- enemyPos={40,100,7,250} with slot3 dead; unitPos={300,480,290,511} with slot1 dead → enemyFront=100, unitFront=290.
- enemyDmg={200,100,0,0}, all live → damageToUnits=255 (saturated). unitDmg={1,64,0,0} → damageToEnemies=65.
- enable=0 for 50 cycles mid-count → no strobes. The counter resumes from its held value and first strobes come the remaining count+5 cycles after enable returns.
- Assert reset during S_SCAN (index 2) → outputs return to reset values, no damageSCEN/moveSCEN that tick. The next tick behaves normally.
- Change unitDead[0] from 1→0 during S_DAMAGE → the published values are unchanged until the next tick's scan.
